// File: rtl/nios_vga_sync_ctrl_pkg.sv
// Shared constants for the VGA sync controller: register map,
// CTRL bit layout, timing-field slots and 640x480@60 defaults.
package nios_vga_sync_ctrl_pkg;

    // Avalon-MM word addresses
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_H_TIMING = 3'd1;
    localparam logic [2:0] ADDR_H_SYNC   = 3'd2;
    localparam logic [2:0] ADDR_V_TIMING = 3'd3;
    localparam logic [2:0] ADDR_V_SYNC   = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;
    localparam logic [2:0] ADDR_FRAME    = 3'd6;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_HS_POL = 1;
    localparam int CTRL_VS_POL = 2;
    localparam int CTRL_IRQ_EN = 3;

    // CTRL register view, LSB is the last member
    typedef struct packed {
        logic irq_en;
        logic vs_pol;
        logic hs_pol;
        logic en;
    } ctrl_t;

    // Slots of the eight timing fields; register N (1..4) holds
    // slot 2*(N-1) in bits [11:0] and slot 2*(N-1)+1 in [27:16].
    localparam int T_H_TOTAL = 0;
    localparam int T_H_ACTIVE = 1;
    localparam int T_H_SYNC_START = 2;
    localparam int T_H_SYNC_END = 3;
    localparam int T_V_TOTAL = 4;
    localparam int T_V_ACTIVE = 5;
    localparam int T_V_SYNC_START = 6;
    localparam int T_V_SYNC_END = 7;
    localparam int T_NUM = 8;

    // 640x480@60 timing
    localparam int DEF_H_TOTAL = 799;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_SYNC_START = 656;
    localparam int DEF_H_SYNC_END = 751;
    localparam int DEF_V_TOTAL = 524;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_SYNC_START = 490;
    localparam int DEF_V_SYNC_END = 491;

    function automatic int timing_default(input int slot);
        case (slot)
            T_H_TOTAL:      return DEF_H_TOTAL;
            T_H_ACTIVE:     return DEF_H_ACTIVE;
            T_H_SYNC_START: return DEF_H_SYNC_START;
            T_H_SYNC_END:   return DEF_H_SYNC_END;
            T_V_TOTAL:      return DEF_V_TOTAL;
            T_V_ACTIVE:     return DEF_V_ACTIVE;
            T_V_SYNC_START: return DEF_V_SYNC_START;
            default:        return DEF_V_SYNC_END;
        endcase
    endfunction

endpackage

// File: rtl/nios_vga_sync_ctrl_timing_counter.sv
// One display axis: position counter plus decode of the next position.
// Ports: run (count enable), step (advance), total/active/sync window,
// pos (registered), pos_nxt, wrap, active_nxt, sync_nxt (next-state decode).
module vga_timing_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] active,
    input  logic [CNT_W-1:0] sync_start,
    input  logic [CNT_W-1:0] sync_end,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] pos_nxt,
    output logic             wrap,
    output logic             active_nxt,
    output logic             sync_nxt
);

    logic [CNT_W-1:0] pos_q;
    logic [CNT_W-1:0] pos_d;

    always_comb begin
        wrap  = run && step && (pos_q == total);
        pos_d = pos_q;
        if (!run) begin
            pos_d = '0;
        end else if (wrap) begin
            pos_d = '0;
        end else if (step) begin
            pos_d = pos_q + 1'b1;
        end
    end

    // Decode the upcoming position so the registered outputs
    // line up with the counter value they describe.
    assign active_nxt = (pos_d < active);
    assign sync_nxt   = (pos_d >= sync_start) && (pos_d <= sync_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos     = pos_q;
    assign pos_nxt = pos_d;

endmodule

// File: rtl/nios_vga_sync_ctrl.sv
// Avalon-MM programmable VGA sync generator with shadowed timing,
// vblank flag/interrupt and frame counter.
// Ports: clk, reset_n; Avalon slave address/chipselect/write_n/
// writedata/readdata; vga_hs/vga_vs/vga_de, h_pos/v_pos, irq.
module nios_vga_sync_ctrl
    import nios_vga_sync_ctrl_pkg::*;
#(
    // Timing fields sit at [CNT_W-1:0] and [16+:CNT_W]; keep CNT_W <= 16.
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [CNT_W-1:0] h_pos,
    output logic [CNT_W-1:0] v_pos,
    output logic             irq
);

    logic wr_en;
    logic is_timing;
    logic [2:0] fld_lo;
    logic [2:0] fld_hi;

    ctrl_t ctrl_q, ctrl_d;
    logic [T_NUM-1:0][CNT_W-1:0] shadow_q, shadow_d;
    logic [T_NUM-1:0][CNT_W-1:0] work_q, work_d;
    logic        flag_q, flag_d;
    logic [31:0] frame_q, frame_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;

    logic run;
    logic h_wrap, v_wrap, frame_wrap;
    logic h_act_nxt, v_act_nxt;
    logic h_sync_nxt, v_sync_nxt;
    logic [CNT_W-1:0] v_pos_nxt;
    logic [CNT_W-1:0] unused_h_nxt;
    logic unused_wdata;
    logic vblank_set;
    logic in_vblank;

    assign unused_wdata = ^writedata;

    assign wr_en     = chipselect && !write_n;
    assign is_timing = (address >= ADDR_H_TIMING) && (address <= ADDR_V_SYNC);
    assign fld_lo    = {address[1:0] - 2'd1, 1'b0};
    assign fld_hi    = {address[1:0] - 2'd1, 1'b1};

    // Counters only advance when enable was and stays high, so the
    // first enabled cycle shows (0,0) and disabling parks them at once.
    assign run = ctrl_q.en && ctrl_d.en;

    vga_timing_counter #(.CNT_W(CNT_W)) u_h_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .step       (1'b1),
        .total      (work_q[T_H_TOTAL]),
        .active     (work_d[T_H_ACTIVE]),
        .sync_start (work_d[T_H_SYNC_START]),
        .sync_end   (work_d[T_H_SYNC_END]),
        .pos        (h_pos),
        .pos_nxt    (unused_h_nxt),
        .wrap       (h_wrap),
        .active_nxt (h_act_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    vga_timing_counter #(.CNT_W(CNT_W)) u_v_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .step       (h_wrap),
        .total      (work_q[T_V_TOTAL]),
        .active     (work_d[T_V_ACTIVE]),
        .sync_start (work_d[T_V_SYNC_START]),
        .sync_end   (work_d[T_V_SYNC_END]),
        .pos        (v_pos),
        .pos_nxt    (v_pos_nxt),
        .wrap       (v_wrap),
        .active_nxt (v_act_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    assign frame_wrap = h_wrap && v_wrap;
    assign vblank_set = h_wrap && (v_pos_nxt == work_q[T_V_ACTIVE]);
    assign in_vblank  = (v_pos >= work_q[T_V_ACTIVE]);

    // Control and shadow registers
    always_comb begin
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        if (wr_en && (address == ADDR_CTRL)) begin
            ctrl_d = ctrl_t'(writedata[3:0]);
        end
        if (wr_en && is_timing) begin
            shadow_d[fld_lo] = writedata[CNT_W-1:0];
            shadow_d[fld_hi] = writedata[16 +: CNT_W];
        end
    end

    // Working set follows the shadow at frame wrap or while idle;
    // the decode uses work_d so (0,0) sees the new timing.
    always_comb begin
        work_d = work_q;
        if (!ctrl_q.en || frame_wrap) begin
            work_d = shadow_q;
        end
    end

    // Vblank flag: a set on the same cycle as a clear wins
    always_comb begin
        flag_d = flag_q;
        if (wr_en && (address == ADDR_STATUS) && writedata[0]) begin
            flag_d = 1'b0;
        end
        if (vblank_set) begin
            flag_d = 1'b1;
        end
    end

    // Frame counter: a write clears and beats a coincident increment
    always_comb begin
        frame_d = frame_q;
        if (wr_en && (address == ADDR_FRAME)) begin
            frame_d = '0;
        end else if (vblank_set) begin
            frame_d = frame_q + 32'd1;
        end
    end

    // Sync and display-enable, idle at the inactive level when disabled
    always_comb begin
        hs_d = ~ctrl_d.hs_pol;
        vs_d = ~ctrl_d.vs_pol;
        de_d = 1'b0;
        if (ctrl_d.en) begin
            hs_d = h_sync_nxt ^ ~ctrl_d.hs_pol;
            vs_d = v_sync_nxt ^ ~ctrl_d.vs_pol;
            de_d = h_act_nxt && v_act_nxt;
        end
    end

    // Read mux, registered every cycle regardless of chipselect
    always_comb begin
        rdata_d = '0;
        unique case (address)
            ADDR_CTRL: begin
                rdata_d[3:0] = ctrl_q;
            end
            ADDR_H_TIMING, ADDR_H_SYNC, ADDR_V_TIMING, ADDR_V_SYNC: begin
                rdata_d[CNT_W-1:0]  = shadow_q[fld_lo];
                rdata_d[16 +: CNT_W] = shadow_q[fld_hi];
            end
            ADDR_STATUS: begin
                rdata_d[0] = flag_q;
                rdata_d[1] = in_vblank;
                rdata_d[16 +: CNT_W] = v_pos;
            end
            ADDR_FRAME: begin
                rdata_d = frame_q;
            end
            default: begin
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
            frame_q <= '0;
            rdata_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            for (int i = 0; i < T_NUM; i++) begin
                shadow_q[i] <= CNT_W'(timing_default(i));
                work_q[i]   <= CNT_W'(timing_default(i));
            end
        end else begin
            ctrl_q   <= ctrl_d;
            flag_q   <= flag_d;
            frame_q  <= frame_d;
            rdata_q  <= rdata_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            shadow_q <= shadow_d;
            work_q   <= work_d;
        end
    end

    assign readdata = rdata_q;
    assign vga_hs   = hs_q;
    assign vga_vs   = vs_q;
    assign vga_de   = de_q;
    assign irq      = flag_q && ctrl_q.irq_en;

endmodule
